keypad_scan_debounce: RTL and testbench
=======================================

Name: keypad_scan_debounce

Overview:
- Upstream stage of the 4-digit countdown timer: drives the 4x4 matrix keypad columns and samples its rows.
- Synchronises and debounces the rows, then delivers one clean 4-bit key code per physical press.
- Gives the timer's digit-load logic a stable value plus a single-cycle strobe, instead of a free-running raw scan.

Parameters:
- SCAN_DIV, 2000: clk cycles each column is driven before its rows are sampled (0.5 ms at 4 MHz). Must be >= 4.
- DEBOUNCE_TICKS, 8: consecutive identical row samples needed to accept a press or a release. Must be >= 1.

Ports:
- clk  in  1  system clock, 4 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- row  in  4  keypad row returns, active-high, asynchronous to clk.
- col  out  4  one-hot column drive, active-high.
- key_code  out  4  last accepted key, code = 4*row_index + col_index.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high while the accepted key remains pressed.

Behaviour:
- Reset values:
  - col = 4'b0001, key_code = 4'h0, key_valid = 0, key_held = 0.
  - Tick counter = 0, debounce count = 0, state = SCAN.
  - Synchroniser flops = 0.
- Row synchroniser: 2-flop per bit. All decisions use the synchronised value, rs.
- Tick generator:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - tick is high for one cycle when the counter equals SCAN_DIV-1.
  - Decisions happen only in tick cycles. Registered results are visible on the following cycle.
- Column index: col 0001 -> 0, 0010 -> 1, 0100 -> 2, 1000 -> 3. Row index uses the same encoding.
- Multiple rows high: the lowest row index wins. Other rows are ignored until release.
- State SCAN:
  - On tick with rs == 0: rotate col left (0001 -> 0010 -> 0100 -> 1000 -> 0001).
  - On tick with rs != 0: latch cand_row (lowest set bit) and cand_code. Set count = 1 and hold col.
  - If DEBOUNCE_TICKS == 1, go directly to the accept action. Otherwise go to DEBOUNCE.
- State DEBOUNCE (col frozen):
  - On tick with rs[cand_row] = 1: count++.
  - When count reaches DEBOUNCE_TICKS, accept: key_code <= cand_code, key_valid pulse, key_held <= 1, count <= 0, go to PRESSED.
  - On tick with rs[cand_row] = 0: go to SCAN, count <= 0, rotate col on that same tick.
- State PRESSED (col frozen, key_held = 1):
  - On tick with rs[cand_row] = 0: count++. When count reaches DEBOUNCE_TICKS: key_held <= 0, count <= 0, rotate col, go to SCAN.
  - On tick with rs[cand_row] = 1: count <= 0.
  - No key_valid while in PRESSED; auto-repeat is not supported.
- key_valid:
  - High for exactly one clk cycle per accepted press.
  - key_code changes in the same cycle that key_valid rises, then holds until the next accept.
- Latency from the first tick that sees the press to key_valid high: (DEBOUNCE_TICKS-1)*SCAN_DIV + 1 clk cycles.
- Reset mid-operation: everything returns to its reset values immediately. No key_valid is emitted while rst_n is low or on the first tick after release.
- A second key pressed while in PRESSED is ignored. Only cand_row in the frozen column is watched.

Decomposition:
- Shared package keypad_pkg:
  - State enum: SCAN, DEBOUNCE, PRESSED.
  - COL_RESET = 4'b0001.
  - Function: one-hot to 2-bit index.
- Sub-module kp_tick_div: parameter SCAN_DIV; ports clk, rst_n, tick.
- The synchroniser, FSM, column shifter and counters stay in the top module.

Test Plan:
- Reset: hold rst_n low for 10 cycles with row = 4'b1111 -> col = 0001, key_code = 0, key_valid = 0, key_held = 0. On release, col rotates every SCAN_DIV cycles while row = 0.
- Clean press (SCAN_DIV = 4, DEBOUNCE_TICKS = 3):
  - Assert row[1] only while col = 0100, for 40 cycles, then release.
  - Expect exactly one key_valid pulse with key_code = 4'h6, and key_held high until 3 low ticks.
  - Expect col to resume rotating from 1000.
- Bounce: row[2] high for 1 tick, low, high for 1 tick, low while col = 0010 -> no key_valid and key_code unchanged.
- Multi-key: row = 4'b1010 while col = 1000 for a full debounce period -> key_code = 4'h7 (row 1, col 3), single pulse.
- Release bounce: after an accepted press, drop row for 2 ticks, raise it for 1 tick, then drop it for 3 ticks -> key_held drops only after the final 3 low ticks, with no second key_valid.
- Reset during DEBOUNCE: assert rst_n mid-count -> outputs go to reset values asynchronously and no key_valid appears afterwards for that press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Provides the FSM state enum, column reset value and a one-hot to index encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } kp_state_e;

    localparam logic [3:0] COL_RESET = 4'b0001;

    // Lowest set bit wins, so this also resolves several rows being high at once.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[3]) idx = 2'd3;
        if (v[2]) idx = 2'd2;
        if (v[1]) idx = 2'd1;
        if (v[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/kp_tick_div.sv
// Scan tick generator: free-running counter 0..SCAN_DIV-1, tick high on SCAN_DIV-1.
// Ports: clk, rst_n (async active-low), tick (one-cycle strobe every SCAN_DIV clocks).
module kp_tick_div #(
    parameter int SCAN_DIV = 2000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(SCAN_DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Keypad scanner: drives one-hot columns, synchronises and debounces the rows,
// and emits one key code plus a single-cycle strobe per physical press.
// Ports: clk, rst_n (async active-low), row[3:0] (async returns),
//        col[3:0] (one-hot drive), key_code[3:0], key_valid (pulse), key_held.
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 2000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_TICKS);

    logic tick;

    kp_tick_div #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    kp_state_e     state_q, state_d;
    logic [3:0]    rs1_q, rs1_d;
    logic [3:0]    rs_q, rs_d;
    logic [3:0]    col_q, col_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [3:0]    cand_code_q, cand_code_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic [CW-1:0] cnt_inc;
    logic [3:0]    col_rot;
    logic [3:0]    new_code;
    logic          hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            rs1_q       <= '0;
            rs_q        <= '0;
            col_q       <= COL_RESET;
            count_q     <= '0;
            cand_row_q  <= '0;
            cand_code_q <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs_q        <= rs_d;
            col_q       <= col_d;
            count_q     <= count_d;
            cand_row_q  <= cand_row_d;
            cand_code_q <= cand_code_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        rs1_d       = row;
        rs_d        = rs1_q;
        state_d     = state_q;
        col_d       = col_q;
        count_d     = count_q;
        cand_row_d  = cand_row_q;
        cand_code_d = cand_code_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        cnt_inc  = count_q + CW'(1);
        col_rot  = {col_q[2:0], col_q[3]};
        new_code = {onehot_to_idx(rs_q), onehot_to_idx(col_q)};
        // Only the latched row in the frozen column is watched.
        hit      = rs_q[cand_row_q];

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (rs_q == 4'b0000) begin
                        col_d = col_rot;
                    end else begin
                        cand_row_d  = onehot_to_idx(rs_q);
                        cand_code_d = new_code;
                        if (DEBOUNCE_TICKS == 1) begin
                            key_code_d  = new_code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            count_d     = '0;
                            state_d     = PRESSED;
                        end else begin
                            count_d = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (hit) begin
                        if (cnt_inc == DB_MAX) begin
                            key_code_d  = cand_code_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            count_d     = '0;
                            state_d     = PRESSED;
                        end else begin
                            count_d = cnt_inc;
                        end
                    end else begin
                        count_d = '0;
                        col_d   = col_rot;
                        state_d = SCAN;
                    end
                end
                PRESSED: begin
                    // Count consecutive low ticks; any high tick restarts release.
                    if (!hit) begin
                        if (cnt_inc == DB_MAX) begin
                            key_held_d = 1'b0;
                            count_d    = '0;
                            col_d      = col_rot;
                            state_d    = SCAN;
                        end else begin
                            count_d = cnt_inc;
                        end
                    end else begin
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    count_d = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        col       = col_q;
        key_code  = key_code_q;
        key_valid = key_valid_q;
        key_held  = key_held_q;
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// Edge counts are relative to the edge where the current column became valid.
module tb_keypad_scan_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks;
    int failures;
    int pulses;
    int base;

    keypad_scan_debounce #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pulses   = 0;
        rst_n    = 1'b0;
        row      = 4'b1111;

        // Reset with every row high
        step(10);
        chk("rst_col", col, 4'b0001);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);

        // Idle scan rotation
        row   = 4'b0000;
        rst_n = 1'b1;
        step(3);
        chk("idle_col_e3", col, 4'b0001);
        step(1);
        chk("idle_col_e4", col, 4'b0010);
        step(4);
        chk("idle_col_e8", col, 4'b0100);

        // Clean press: row[1] in column 2 -> code 6
        base = pulses;
        row  = 4'b0010;
        step(11);
        chk("press_valid_e11", key_valid, 1'b0);
        chk("press_held_e11", key_held, 1'b0);
        chk("press_col_frozen", col, 4'b0100);
        step(1);
        chk("press_valid_e12", key_valid, 1'b1);
        chk("press_code_e12", key_code, 4'h6);
        chk("press_held_e12", key_held, 1'b1);
        step(1);
        chk("press_valid_e13", key_valid, 1'b0);
        step(27);
        row = 4'b0000;
        step(11);
        chk("rel_held_e51", key_held, 1'b1);
        step(1);
        chk("rel_held_e52", key_held, 1'b0);
        chk("rel_col_e52", col, 4'b1000);
        chk("press_pulses", pulses - base, 1);

        // Multi-key in column 3: row 1 wins -> code 7
        base = pulses;
        row  = 4'b1010;
        step(12);
        chk("multi_valid", key_valid, 1'b1);
        chk("multi_code", key_code, 4'h7);

        // Release bounce: low 2 ticks, high 1 tick, low 3 ticks
        step(4);
        row = 4'b0000;
        step(8);
        chk("rb_held_low2", key_held, 1'b1);
        row = 4'b1010;
        step(4);
        row = 4'b0000;
        step(11);
        chk("rb_held_e39", key_held, 1'b1);
        step(1);
        chk("rb_held_e40", key_held, 1'b0);
        chk("rb_col_e40", col, 4'b0001);
        chk("multi_pulses", pulses - base, 1);

        // Bounce: single-tick blips never accepted
        step(4);
        chk("bnc_col_start", col, 4'b0010);
        base = pulses;
        row  = 4'b0100;
        step(4);
        row = 4'b0000;
        step(4);
        chk("bnc_col_mid", col, 4'b0100);
        row = 4'b0100;
        step(4);
        row = 4'b0000;
        step(4);
        chk("bnc_col_end", col, 4'b1000);
        chk("bnc_pulses", pulses - base, 0);
        chk("bnc_code", key_code, 4'h7);
        chk("bnc_held", key_held, 1'b0);

        // Reset during DEBOUNCE
        base = pulses;
        row  = 4'b0001;
        step(6);
        rst_n = 1'b0;
        #1;
        chk("mrst_col", col, 4'b0001);
        chk("mrst_code", key_code, 4'h0);
        chk("mrst_valid", key_valid, 1'b0);
        chk("mrst_held", key_held, 1'b0);
        row = 4'b0000;
        step(3);
        rst_n = 1'b1;
        step(4);
        chk("mrst_col_e4", col, 4'b0010);
        step(20);
        chk("mrst_pulses", pulses - base, 0);
        chk("mrst_code_after", key_code, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
